// File: rtl/uart_rx_flow.sv
// UART receiver with a first-word-fall-through receive FIFO and RTS flow control.
// Optional: define UART_RX_BREAK_DETECT_EN to report all-zero frames on break_det.
module uart_rx_flow #(
  parameter int CLKS_PER_BIT  = 16,
  parameter int DATA_BITS     = 8,
  parameter int PARITY_MODE   = 0,
  parameter int FIFO_DEPTH    = 16,
  parameter int RTS_THRESHOLD = FIFO_DEPTH - 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          rts_n,
  output logic                          rx_busy,
  output logic                          frame_error,
  output logic                          parity_error,
  output logic                          overrun_error,
  output logic                          break_det,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int CNTW = $clog2(CLKS_PER_BIT);
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(CLKS_PER_BIT - 1);
  localparam logic [CNTW-1:0] CNT_HALF = CNTW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0]      LAST_BIT = 4'(DATA_BITS - 1);
  localparam logic [CW-1:0]   DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]   RTS_TH   = CW'(RTS_THRESHOLD);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // Synchroniser and edge detector; all reset high to match an idle line.
  logic rx_meta, rx_s, rx_prev;
  logic rx_fall;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign rx_fall = rx_prev & ~rx_s;

  state_t                 state, state_d;
  logic [CNTW-1:0]        cnt, cnt_d;
  logic [3:0]             bit_idx, bit_d;
  logic [DATA_BITS-1:0]   shreg, shreg_d;
  logic                   par_bad, par_bad_d;
  logic                   hold, hold_d;
  logic                   exp_par, is_break;
  logic                   push, perr_p, ferr_p, brk_p;

`ifdef UART_RX_BREAK_DETECT_EN
  logic par_bit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                 par_bit <= 1'b0;
    else if (state == PARITY && cnt == CNT_FULL) par_bit <= rx_s;
  end

  // Break: every data bit, the parity bit (if any) and the stop bit sampled low.
  assign is_break = (shreg == '0) && !rx_s && (PARITY_MODE == 0 || !par_bit);
`else
  assign is_break = 1'b0;
`endif

  assign exp_par = (PARITY_MODE == 2) ? ~^shreg : ^shreg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_bad <= 1'b0;
      hold    <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bit_idx <= bit_d;
      shreg   <= shreg_d;
      par_bad <= par_bad_d;
      hold    <= hold_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt + 1'b1;
    bit_d     = bit_idx;
    shreg_d   = shreg;
    par_bad_d = par_bad;
    hold_d    = hold;
    push      = 1'b0;
    perr_p    = 1'b0;
    ferr_p    = 1'b0;
    brk_p     = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_d     = '0;
        par_bad_d = 1'b0;
        hold_d    = 1'b0;
        if (rx_fall) state_d = START;
      end
      START: if (cnt == CNT_HALF) begin
        cnt_d   = '0;
        bit_d   = '0;
        state_d = rx_s ? IDLE : DATA;
      end
      DATA: if (cnt == CNT_FULL) begin
        cnt_d   = '0;
        shreg_d = {rx_s, shreg[DATA_BITS-1:1]};
        if (bit_idx == LAST_BIT) state_d = (PARITY_MODE == 0) ? STOP : PARITY;
        else                     bit_d   = bit_idx + 1'b1;
      end
      PARITY: if (cnt == CNT_FULL) begin
        cnt_d     = '0;
        par_bad_d = (rx_s != exp_par);
        state_d   = STOP;
      end
      STOP: begin
        if (hold) begin
          // Discarded frame: stay busy until the line returns to idle.
          cnt_d = '0;
          if (rx_s) state_d = IDLE;
        end else if (cnt == CNT_FULL) begin
          cnt_d = '0;
          if (is_break)     brk_p  = 1'b1;
          else if (par_bad) perr_p = 1'b1;
          else if (!rx_s)   ferr_p = 1'b1;
          else              push   = 1'b1;
          state_d = rx_s ? IDLE : STOP;
          hold_d  = !rx_s;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_busy = (state != IDLE);

  // Receive FIFO; a push into a full FIFO is accepted only alongside a pop.
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wptr, rptr;
  logic                 pop, full, push_ok;

  assign rx_valid = (fifo_count != '0);
  assign full     = (fifo_count == DEPTH_C);
  assign pop      = rx_valid & rx_ready;
  assign push_ok  = push & (~full | pop);
  assign rx_data  = mem[rptr];

  // NOTE: storage is left unreset; fifo_count gates rx_valid, so stale entries are never seen.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= shreg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr          <= '0;
      rptr          <= '0;
      fifo_count    <= '0;
      rts_n         <= 1'b1;
      frame_error   <= 1'b0;
      parity_error  <= 1'b0;
      overrun_error <= 1'b0;
      break_det     <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      rts_n         <= (fifo_count >= RTS_TH);
      frame_error   <= ferr_p;
      parity_error  <= perr_p;
      overrun_error <= push & full & ~pop;
      break_det     <= brk_p;
    end
  end

endmodule
